// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for a bank of common-anode/common-cathode seven
// segment digits. A shadow copy of the hex nibbles and decimal points is
// captured on i_load. Each digit is driven in turn for TICKS_PER_DIGIT clock
// cycles. Optional leading-zero blanking is applied from the live
// i_blank_lz input.
//
// Parameters
//   NUM_DIGITS      number of multiplexed digits (1..8)
//   TICKS_PER_DIGIT clock cycles each digit is driven (>= 1)
//   ACTIVE_LOW_SEG  1 = o_seg / o_dp are inverted at the pins
//   ACTIVE_LOW_AN   1 = o_an is inverted at the pins
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       synchronous active-low reset
//   i_data        hex nibbles, nibble k drives digit k (digit 0 = LSB nibble)
//   i_dp          decimal-point request per digit
//   i_load        capture strobe for i_data / i_dp into the shadow registers
//   i_blank_lz    leading-zero blanking enable (used live, not shadowed)
//   o_seg         registered segments, bit order gfedcba
//   o_dp          registered decimal point of the active digit
//   o_an          registered one-hot digit enable
//   o_frame_done  registered one-cycle pulse as the scan wraps back to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 1000,
    parameter bit ACTIVE_LOW_SEG  = 1'b0,
    parameter bit ACTIVE_LOW_AN   = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_blank_lz,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_done
);

    // Counter widths never collapse to zero bits, so NUM_DIGITS=1 and
    // TICKS_PER_DIGIT=1 still give well-formed (constant) registers.
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);

    // Pin-level inversion masks, applied after the logical encoding.
    localparam logic [6:0]            SEG_INV = {7{ACTIVE_LOW_SEG}};
    localparam logic                  DP_INV  = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{ACTIVE_LOW_AN}};

    // ST_PRIME is the single cycle after reset release: digit 0 is put on
    // the outputs without advancing the tick counter, so that the first
    // digit after reset is held for the full TICKS_PER_DIGIT cycles.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    state_t                  state_p0;
    state_t                  state_d;

    logic [TICK_W-1:0]       tick_p0;
    logic [TICK_W-1:0]       tick_d;
    logic [IDX_W-1:0]        idx_p0;
    logic [IDX_W-1:0]        idx_d;
    logic                    frame_d;

    logic [4*NUM_DIGITS-1:0] shadow_data_p0;
    logic [NUM_DIGITS-1:0]   shadow_dp_p0;

    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    upper_zero;
    logic [3:0]              nib_d;
    logic                    blank_d;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic                    frame_p1;

    // Logical (active-high) segment pattern for one hex nibble, gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h67;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: scan control (state, tick counter, digit index)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_p0 <= ST_PRIME;
        end else begin
            state_p0 <= state_d;
        end
    end

    always_comb begin
        state_d = state_p0;
        tick_d  = tick_p0;
        idx_d   = idx_p0;
        frame_d = 1'b0;
        case (state_p0)
            ST_PRIME: begin
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (tick_p0 == TICK_LAST) begin
                    tick_d = '0;
                    if (idx_p0 == IDX_LAST) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                    end else begin
                        idx_d = idx_p0 + IDX_W'(1);
                    end
                end else begin
                    tick_d = tick_p0 + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    // zero_from[k] is set when nibbles NUM_DIGITS-1..k of the shadow are
    // all zero, i.e. digit k is a leading zero.
    always_comb begin
        zero_from  = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero   = upper_zero & (shadow_data_p0[k*4 +: 4] == 4'h0);
            zero_from[k] = upper_zero;
        end
    end

    // Content for the digit that becomes active at this edge. It is taken
    // from the shadow as it stands before any coincident load, so a load
    // shows up one edge later.
    always_comb begin
        nib_d   = 4'h0;
        dp_d    = 1'b0;
        an_d    = '0;
        blank_d = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib_d   = shadow_data_p0[k*4 +: 4];
                dp_d    = shadow_dp_p0[k];
                an_d[k] = 1'b1;
                blank_d = i_blank_lz && (k != 0) && zero_from[k];
            end
        end
        seg_d = blank_d ? 7'h00 : hex_to_seg(nib_d);
    end

    // ------------------------------------------------------------------
    // Stage p1: shadow capture and registered pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_p0        <= '0;
            idx_p0         <= '0;
            shadow_data_p0 <= '0;
            shadow_dp_p0   <= '0;
            seg_p1         <= SEG_INV;
            dp_p1          <= DP_INV;
            an_p1          <= AN_INV;
            frame_p1       <= 1'b0;
        end else begin
            tick_p0  <= tick_d;
            idx_p0   <= idx_d;
            if (i_load) begin
                shadow_data_p0 <= i_data;
                shadow_dp_p0   <= i_dp;
            end
            seg_p1   <= seg_d ^ SEG_INV;
            dp_p1    <= dp_d ^ DP_INV;
            an_p1    <= an_d ^ AN_INV;
            frame_p1 <= frame_d;
        end
    end

    assign o_seg        = seg_p1;
    assign o_dp         = dp_p1;
    assign o_an         = an_p1;
    assign o_frame_done = frame_p1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Two scanners (NUM_DIGITS=4, TICKS_PER_DIGIT=3) share the same stimulus:
// one with active-high pins, one with both polarities inverted. A
// behavioural model derives the expected display from the number of
// cycles since reset release and the shadow contents; it is compared
// against both instances every cycle. Directed sequences pin the model
// with hand-computed literal values, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int T = 3;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  data;
    logic [3:0]   dpin;
    logic         load;
    logic         blank_lz;

    logic [6:0]   seg,   seg_i;
    logic         dpo,   dpo_i;
    logic [3:0]   an,    an_i;
    logic         fd,    fd_i;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_dp(dpin), .i_load(load),
        .i_blank_lz(blank_lz), .o_seg(seg), .o_dp(dpo), .o_an(an), .o_frame_done(fd)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) dut_inv (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_dp(dpin), .i_load(load),
        .i_blank_lz(blank_lz), .o_seg(seg_i), .o_dp(dpo_i), .o_an(an_i), .o_frame_done(fd_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          e = 0;            // edges since reset release
    bit          model_valid = 1'b0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_dp = '0;
    logic [6:0]  exp_seg = '0, exp_seg_i = '0;
    logic        exp_dp = 1'b0, exp_dp_i = 1'b0, exp_fd = 1'b0;
    logic [3:0]  exp_an = '0, exp_an_i = '0;

    always @(posedge clk) begin
        int   d;
        logic [3:0] nib;
        logic blank;
        if (!rst_n) begin
            e        = 0;
            m_shadow = '0;
            m_dp     = '0;
            exp_seg  = '0;
            exp_dp   = 1'b0;
            exp_an   = '0;
            exp_fd   = 1'b0;
        end else begin
            e++;
            d       = ((e - 1) / T) % N;
            nib     = 4'(m_shadow >> (4 * d));
            blank   = blank_lz && (d > 0) && ((m_shadow >> (4 * d)) == 16'd0);
            exp_seg = blank ? 7'h00 : HEX[nib];
            exp_dp  = m_dp[d];
            exp_an  = 4'(1 << d);
            exp_fd  = (e > 1) && (((e - 1) % (T * N)) == 0);
            if (load) begin
                m_shadow = data;
                m_dp     = dpin;
            end
        end
        exp_seg_i   = exp_seg ^ 7'h7F;
        exp_dp_i    = ~exp_dp;
        exp_an_i    = ~exp_an;
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cmp_seg",    32'(seg),   32'(exp_seg));
            chk("cmp_dp",     32'(dpo),   32'(exp_dp));
            chk("cmp_an",     32'(an),    32'(exp_an));
            chk("cmp_fd",     32'(fd),    32'(exp_fd));
            chk("cmp_seg_inv", 32'(seg_i), 32'(exp_seg_i));
            chk("cmp_dp_inv",  32'(dpo_i), 32'(exp_dp_i));
            chk("cmp_an_inv",  32'(an_i),  32'(exp_an_i));
            chk("cmp_fd_inv",  32'(fd_i),  32'(exp_fd));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fd !== 1'b1 && n < 100);
        chk({tag, "_frame_seen"}, 32'(fd), 32'd1);
    endtask

    // Called on the first cycle of a frame; checks all 12 cycles against
    // literal per-digit segment values {d3,d2,d1,d0} and dp bits.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [6:0] s, si;
        logic [3:0] a, ai;
        logic       dd, f;
        for (int i = 0; i < 12; i++) begin
            s  = segs[(i / 3) * 7 +: 7];
            si = s ^ 7'h7F;
            a  = 4'(1 << (i / 3));
            ai = ~a;
            dd = dps[i / 3];
            f  = (i == 0);
            chk({tag, "_seg"},     32'(seg),   32'(s));
            chk({tag, "_an"},      32'(an),    32'(a));
            chk({tag, "_dp"},      32'(dpo),   32'(dd));
            chk({tag, "_fd"},      32'(fd),    32'(f));
            chk({tag, "_seg_inv"}, 32'(seg_i), 32'(si));
            chk({tag, "_an_inv"},  32'(an_i),  32'(ai));
            @(negedge clk);
        end
    endtask

    task automatic load_value(input logic [15:0] v, input logic [3:0] p);
        data = v;
        dpin = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic f;
        logic [3:0] a;
        rst_n    = 1'b0;
        data     = 16'h0;
        dpin     = 4'h0;
        load     = 1'b0;
        blank_lz = 1'b0;

        // Reset held two cycles.
        @(negedge clk);
        @(negedge clk);
        chk("rst_an",      32'(an),    32'h0);
        chk("rst_seg",     32'(seg),   32'h00);
        chk("rst_dp",      32'(dpo),   32'h0);
        chk("rst_fd",      32'(fd),    32'h0);
        chk("rst_seg_inv", 32'(seg_i), 32'h7F);
        chk("rst_an_inv",  32'(an_i),  32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_seg", 32'(seg), 32'h3F);
        chk("rel_an",  32'(an),  32'h1);
        chk("rel_fd",  32'(fd),  32'h0);

        // Scan of 0x1A3F with dp on digit 2.
        load_value(16'h1A3F, 4'b0100);
        wait_frame("scan");
        check_frame("scan", {7'h06, 7'h77, 7'h4F, 7'h71}, 4'b0100);

        // Free run: one frame_done every 12 cycles, aligned with digit 0.
        for (int i = 0; i < 30; i++) begin
            f = ((i % 12) == 0);
            a = 4'(1 << ((i / 3) % 4));
            chk("run_fd", 32'(fd), 32'(f));
            chk("run_an", 32'(an), 32'(a));
            @(negedge clk);
        end

        // Load on the index-advance edge: digit 1 shows old '3' then new '5'.
        wait_frame("corner");
        @(negedge clk);
        @(negedge clk);
        data = 16'h1A5F;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("adv_old_seg", 32'(seg), 32'h4F);
        chk("adv_old_an",  32'(an),  32'h2);
        @(negedge clk);
        chk("adv_new_seg", 32'(seg), 32'h6D);

        // Reset with load asserted in the middle of digit 2.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_an", 32'(an), 32'h4);
        rst_n = 1'b0;
        data  = 16'hFFFF;
        dpin  = 4'hF;
        load  = 1'b1;
        @(negedge clk);
        chk("midrst_an",  32'(an),  32'h0);
        chk("midrst_seg", 32'(seg), 32'h00);
        chk("midrst_fd",  32'(fd),  32'h0);
        @(negedge clk);
        chk("midrst2_an", 32'(an), 32'h0);
        rst_n = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        chk("post_seg", 32'(seg), 32'h3F);
        chk("post_an",  32'(an),  32'h1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("post_d1_seg", 32'(seg), 32'h3F);
        chk("post_d1_an",  32'(an),  32'h2);
        chk("post_d1_dp",  32'(dpo), 32'h0);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load_value(16'h0050, 4'b0000);
        wait_frame("blank50");
        check_frame("blank50", {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
        load_value(16'h0000, 4'b0000);
        wait_frame("blank00");
        check_frame("blank00", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
        blank_lz = 1'b0;
        wait_frame("noblank");
        check_frame("noblank", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);

        // All-eights: inverted instance shows 00 with one-cold anodes.
        load_value(16'h8888, 4'b1001);
        wait_frame("eights");
        check_frame("eights", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1001);

        // Randomized run, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) data = 16'($urandom_range(0, 255));
            else                           data = 16'($urandom);
            dpin  = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
